instr_fetch: RTL and testbench

//   Instruction fetch stage of the 8-bit CPU. Owns the program counter and drives the

---
 rtl/cpu_isa_pkg.sv | 35 +++
 rtl/ifetch_pc.sv | 60 ++++++
 rtl/instr_fetch.sv | 153 +++++++++++++++
 tb/tb_instr_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// cpu_isa_pkg
//   Shared ISA definitions for the 8-bit CPU: opcode values (upper nibble of
//   the first instruction byte), the instruction-length helper and the fetch
//   stage state type.
//   No ports; imported by instr_fetch.
// -----------------------------------------------------------------------------
package cpu_isa_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDO = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STO = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_ARG,
        ISSUE,
        HALTED
    } fetch_state_t;

    // Opcodes that carry a second (operand/address) byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == OP_LDO) || (op == OP_LDA) || (op == OP_STO) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/ifetch_pc.sv
// -----------------------------------------------------------------------------
// ifetch_pc
//   Program counter for the fetch stage: jump load, increment, and a sticky
//   overflow flag raised by an increment from the all-ones address.
//   Build option: IFETCH_PC_WRAP_EN defined -> increments simply wrap and the
//   overflow flag is tied low.
// Ports
//   clk       in   1       clock, rising edge
//   rst_n     in   1       asynchronous active-low reset (pc <= RESET_PC)
//   load      in   1       load pc from load_val (takes priority over inc)
//   load_val  in   ADDR_W  jump target
//   inc       in   1       pc <= pc + 1
//   pc        out  ADDR_W  current program counter
//   ovf       out  1       sticky: an increment from the last address happened
// -----------------------------------------------------------------------------
module ifetch_pc #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              ovf
);

    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else if (load) begin
            pc_reg <= load_val;
        end else if (inc) begin
            pc_reg <= pc_reg + ADDR_W'(1);
        end
    end

    assign pc = pc_reg;

`ifdef IFETCH_PC_WRAP_EN
    assign ovf = 1'b0;
`else
    logic ovf_reg;

    // Once set, only reset clears it: the fetch stage treats it as a fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (inc && !load && (&pc_reg)) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. Reads 1- or 2-byte instructions from the program
//   ROM, assembles them into an instruction register and presents them to the
//   decoder over valid/ready. JMP is resolved here and never issued. After HLT
//   is accepted (or a PC overflow fault) the stage stops until reset.
//   Build option: IFETCH_PC_WRAP_EN defined -> the PC wraps from the last
//   address to 0 and fetch_err is tied low; otherwise running past the last
//   address is a fault that halts the stage with fetch_err=1.
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   rom_addr/read/ena (out)  ROM byte address and strobes (active in fetch states)
//   rom_data (in)            ROM byte, combinational from rom_addr
//   ir_valid (out)/ir_ready  decoder handshake
//   ir_opcode/operand/pc     assembled instruction and its address
//   halted, fetch_err (out)  stopped; stopped because of a PC overflow fault
// -----------------------------------------------------------------------------
module instr_fetch
    import cpu_isa_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read,
    output logic              rom_ena,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_opcode,
    output logic [DATA_W-1:0] ir_operand,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              halted,
    output logic              fetch_err
);

`ifdef IFETCH_PC_WRAP_EN
    localparam bit PC_WRAP = 1'b1;
`else
    localparam bit PC_WRAP = 1'b0;
`endif

    fetch_state_t      state_reg, state_next;
    logic [DATA_W-1:0] ir_opcode_reg, ir_operand_reg;
    logic [ADDR_W-1:0] ir_pc_reg, addr_hold_reg;

    logic [ADDR_W-1:0] pc;
    logic              pc_ovf, pc_inc, pc_load, fetching;
    logic [3:0]        rom_op, ir_op;

    assign rom_op = rom_data[DATA_W-1 -: 4];
    assign ir_op  = ir_opcode_reg[DATA_W-1 -: 4];

    ifetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (ADDR_W'(rom_data)),
        .inc      (pc_inc),
        .pc       (pc),
        .ovf      (pc_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FETCH_OP;
            ir_opcode_reg  <= '0;
            ir_operand_reg <= '0;
            ir_pc_reg      <= '0;
            addr_hold_reg  <= RESET_PC;
        end else begin
            state_reg <= state_next;
            if (fetching) begin
                addr_hold_reg <= pc;
            end
            if (state_reg == FETCH_OP) begin
                ir_opcode_reg  <= rom_data;
                ir_pc_reg      <= pc;
                ir_operand_reg <= '0;
            end
            if (state_reg == FETCH_ARG) begin
                ir_operand_reg <= rom_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        fetching   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        unique case (state_reg)
            FETCH_OP: begin
                fetching = 1'b1;
                pc_inc   = 1'b1;
                if (is_two_byte(rom_op)) begin
                    // Without wrap there is no address left for the operand.
                    if (!PC_WRAP && (&pc)) begin
                        state_next = HALTED;
                    end else begin
                        state_next = FETCH_ARG;
                    end
                end else begin
                    state_next = ISSUE;
                end
            end
            FETCH_ARG: begin
                fetching = 1'b1;
                if (ir_op == OP_JMP) begin
                    pc_load    = 1'b1;
                    state_next = FETCH_OP;
                end else begin
                    pc_inc     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // An overflowed PC has nowhere valid to fetch from next.
                if (ir_ready) begin
                    state_next = (ir_op == OP_HLT || pc_ovf) ? HALTED : FETCH_OP;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = FETCH_OP;
            end
        endcase
    end

    assign rom_read   = fetching;
    assign rom_ena    = fetching;
    assign rom_addr   = fetching ? pc : addr_hold_reg;
    assign ir_valid   = (state_reg == ISSUE);
    assign halted     = (state_reg == HALTED);
    assign ir_opcode  = ir_opcode_reg;
    assign ir_operand = ir_operand_reg;
    assign ir_pc      = ir_pc_reg;

`ifdef IFETCH_PC_WRAP_EN
    assign fetch_err = 1'b0;
`else
    assign fetch_err = halted && pc_ovf;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Bench for instr_fetch. Directed table of small programs, hand-written
//   stall/reset sequences, and random programs with random decoder back
//   pressure, all compared cycle by cycle against a transaction-level model of
//   the fetch rules (instruction lengths, latencies, JMP, HLT, end-of-memory).
//   Honours IFETCH_PC_WRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

`ifdef IFETCH_PC_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int HMAX = 256;

    logic       clk, rst_n;
    logic [7:0] rom_addr, rom_data, ir_opcode, ir_operand, ir_pc;
    logic       rom_read, rom_ena, ir_valid, ir_ready, halted, fetch_err;

    logic [7:0] rom [256];
    // ROM drives nothing while disabled; a floating bus reads as zero here.
    assign rom_data = rom_ena ? rom[rom_addr] : 8'h00;

    instr_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_addr   (rom_addr),
        .rom_read   (rom_read),
        .rom_ena    (rom_ena),
        .rom_data   (rom_data),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .ir_pc      (ir_pc),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    string tname;

    // Per-cycle expectations produced by the model.
    bit         ready_pat [HMAX];
    bit         e_valid [HMAX], e_ena [HMAX], e_halt [HMAX], e_err [HMAX];
    logic [7:0] e_addr [HMAX], e_op [HMAX], e_arg [HMAX], e_pc [HMAX];

    logic [31:0] got_q [$];   // {opcode, operand, pc, cycle} of each transfer
    logic        last_halt, last_err;

    typedef struct {
        string            name;
        int               n_poke;
        logic [4:0][15:0] pk;      // {addr, data}
        int               n_exp;
        logic [2:0][31:0] ex;      // {opcode, operand, pc, cycle}
        bit               exact;   // transfer count must equal n_exp
        bit               halt;
        bit               err;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mkv(string n, int np, logic [15:0] p0, logic [15:0] p1,
                                 logic [15:0] p2, logic [15:0] p3, logic [15:0] p4,
                                 int ne, logic [31:0] x0, logic [31:0] x1, logic [31:0] x2,
                                 bit exact, bit h, bit e);
        vec_t v;
        v.name = n;  v.n_poke = np;
        v.pk[0] = p0; v.pk[1] = p1; v.pk[2] = p2; v.pk[3] = p3; v.pk[4] = p4;
        v.n_exp = ne;
        v.ex[0] = x0; v.ex[1] = x1; v.ex[2] = x2;
        v.exact = exact; v.halt = h; v.err = e;
        return v;
    endfunction

    function automatic bit two_byte(input logic [3:0] op);
        return op == 4'h1 || op == 4'h2 || op == 4'h3 || op == 4'hA;
    endfunction

    // Walks the program instruction by instruction. An instruction fetched in
    // cycle t is valid from t+1 (1-byte) or t+2 (2-byte); it is accepted in the
    // first ready cycle from then on, and the next fetch follows one cycle later.
    // A JMP refetches at its target two cycles after its opcode fetch.
    task automatic build_model(input int h);
        int t, pc, a, first, ip, halt_at;
        bit ovf, err;
        logic [7:0] op, arg;
        for (int k = 0; k < HMAX; k++) begin
            e_valid[k] = 0; e_ena[k] = 0; e_halt[k] = 0; e_err[k] = 0;
            e_addr[k] = 0; e_op[k] = 0; e_arg[k] = 0; e_pc[k] = 0;
        end
        t = 0; pc = 0; ovf = 0; err = 0; halt_at = h;
        while (t < h) begin
            op = rom[pc];
            e_ena[t] = 1; e_addr[t] = 8'(pc);
            if (two_byte(op[7:4])) begin
                if (pc == 255 && !WRAP) begin
                    halt_at = t + 1; err = 1;
                    break;
                end
                if (t + 1 < h) begin
                    e_ena[t+1] = 1; e_addr[t+1] = 8'((pc + 1) % 256);
                end
                arg = rom[(pc + 1) % 256];
                if (op[7:4] == 4'hA) begin
                    pc = int'(arg); t = t + 2;
                    continue;
                end
                if (pc + 1 == 255 && !WRAP) ovf = 1;
                ip = pc; pc = (pc + 2) % 256; first = t + 2;
            end else begin
                if (pc == 255 && !WRAP) ovf = 1;
                arg = 8'h00; ip = pc; pc = (pc + 1) % 256; first = t + 1;
            end
            a = first;
            while (a < h && !ready_pat[a]) a++;
            for (int c = first; c < h && c <= a; c++) begin
                e_valid[c] = 1; e_op[c] = op; e_arg[c] = arg; e_pc[c] = 8'(ip);
            end
            if (a >= h) break;
            if (op[7:4] == 4'hF || ovf) begin
                halt_at = a + 1; err = ovf;
                break;
            end
            t = a + 1;
        end
        for (int k = halt_at; k < h; k++) begin
            e_halt[k] = 1; e_err[k] = err;
        end
    endtask

    task automatic chk(input string what, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s %s: got %h required %h", tname, what, got, exp);
        end
    endtask

    // Holds reset for a cycle, checks the reset state, releases at a negedge.
    task automatic apply_reset();
        rst_n = 1'b0;
        ir_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_state", {ir_valid, halted, fetch_err, ir_opcode, ir_operand, ir_pc},
            {3'b000, 24'h000000});
        chk("reset_addr", {24'h0, rom_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs h cycles from reset release, comparing every cycle with the model.
    task automatic run_check(input int h);
        bit ok;
        build_model(h);
        got_q.delete();
        for (int k = 0; k < h; k++) begin
            #1;
            ir_ready = ready_pat[k];
            #1;
            vectors++;
            ok = (ir_valid === e_valid[k]) && (halted === e_halt[k]) &&
                 (fetch_err === e_err[k]) && (rom_ena === e_ena[k]) &&
                 (rom_read === e_ena[k]) && (!e_ena[k] || rom_addr === e_addr[k]) &&
                 (!e_valid[k] || (ir_opcode === e_op[k] && ir_operand === e_arg[k] &&
                                  ir_pc === e_pc[k]));
            if (!ok) begin
                miscompares++;
                $display("FAIL %s cycle %0d (got/required): valid %b/%b halted %b/%b err %b/%b ena %b/%b read %b addr %h/%h op %h/%h arg %h/%h pc %h/%h",
                         tname, k, ir_valid, e_valid[k], halted, e_halt[k], fetch_err, e_err[k],
                         rom_ena, e_ena[k], rom_read, rom_addr, e_addr[k], ir_opcode, e_op[k],
                         ir_operand, e_arg[k], ir_pc, e_pc[k]);
            end
            if (ir_valid && ir_ready) got_q.push_back({ir_opcode, ir_operand, ir_pc, 8'(k)});
            last_halt = halted;
            last_err  = fetch_err;
            @(negedge clk);
        end
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    endtask

    initial begin
        logic [7:0] b;
        int thr;
        rst_n = 1'b0;
        ir_ready = 1'b0;
        clear_rom();

        // ---------------- directed table (ready held high) ----------------
        tbl[0] = mkv("T1_one_byte", 3, 16'h0080, 16'h0191, 16'h02B0, 0, 0,
                     3, 32'h80_00_00_01, 32'h91_00_01_03, 32'hB0_00_02_05, 0, 0, 0);
        tbl[1] = mkv("T2_two_byte", 3, 16'h0011, 16'h0141, 16'h02F0, 0, 0,
                     2, 32'h11_41_00_02, 32'hF0_00_02_04, 0, 1, 1, 0);
        tbl[2] = mkv("T3_jmp", 5, 16'h00A0, 16'h0107, 16'h07A3, 16'h080F, 16'h0FF5,
                     1, 32'hF5_00_0F_05, 0, 0, 1, 1, 0);
        tbl[3] = mkv("T5_hlt", 1, 16'h03F0, 0, 0, 0, 0,
                     3, 32'h00_00_00_01, 32'h00_00_01_03, 32'h00_00_02_05, 0, 1, 0);
        tbl[4] = mkv("T8_jmp_arg_at_ff", 5, 16'h00A0, 16'h01FE, 16'hFEA0, 16'hFF05, 16'h05F1,
                     1, 32'hF1_00_05_05, 0, 0, 1, 1, 0);
`ifdef IFETCH_PC_WRAP_EN
        tbl[5] = mkv("T6_two_byte_at_ff", 3, 16'h00A0, 16'h01FF, 16'hFF11, 0, 0,
                     2, 32'h11_A0_FF_04, 32'hFF_00_01_06, 0, 1, 1, 0);
        tbl[6] = mkv("T7_one_byte_at_ff", 3, 16'h00A0, 16'h01FF, 16'hFF80, 0, 0,
                     2, 32'h80_00_FF_03, 32'h80_00_FF_07, 0, 0, 0, 0);
        tbl[7] = mkv("T9_arg_at_ff", 4, 16'h00A0, 16'h01FE, 16'hFE21, 16'hFF33, 0,
                     2, 32'h21_33_FE_04, 32'h21_33_FE_09, 0, 0, 0, 0);
`else
        tbl[5] = mkv("T6_two_byte_at_ff", 3, 16'h00A0, 16'h01FF, 16'hFF11, 0, 0,
                     0, 0, 0, 0, 1, 1, 1);
        tbl[6] = mkv("T7_one_byte_at_ff", 3, 16'h00A0, 16'h01FF, 16'hFF80, 0, 0,
                     1, 32'h80_00_FF_03, 0, 0, 1, 1, 1);
        tbl[7] = mkv("T9_arg_at_ff", 4, 16'h00A0, 16'h01FE, 16'hFE21, 16'hFF33, 0,
                     1, 32'h21_33_FE_04, 0, 0, 1, 1, 1);
`endif

        for (int k = 0; k < HMAX; k++) ready_pat[k] = 1;
        for (int i = 0; i < 8; i++) begin
            clear_rom();
            for (int j = 0; j < tbl[i].n_poke; j++) rom[tbl[i].pk[j][15:8]] = tbl[i].pk[j][7:0];
            tname = tbl[i].name;
            apply_reset();
            run_check(40);
            for (int j = 0; j < tbl[i].n_exp; j++) begin
                if (j < got_q.size()) begin
                    chk($sformatf("xfer%0d", j), got_q[j], tbl[i].ex[j]);
                end else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL %s xfer%0d: got none required %h", tname, j, tbl[i].ex[j]);
                end
            end
            if (tbl[i].exact) chk("xfer_count", 32'(got_q.size()), 32'(tbl[i].n_exp));
            chk("end_halt_err", {30'h0, last_halt, last_err}, {30'h0, tbl[i].halt, tbl[i].err});
        end

        // ---------------- T4: stall in ISSUE, then T5-style restart ----------------
        tname = "T4_stall";
        clear_rom();
        rom[0] = 8'h80; rom[1] = 8'hF0;
        apply_reset();
        ir_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("stall_ir", {7'h0, ir_valid, ir_opcode, ir_operand, ir_pc}, {7'h0, 1'b1, 24'h800000});
            chk("stall_rom", {22'h0, rom_ena, rom_read, rom_addr}, 32'h0);
            @(negedge clk);
        end
        ir_ready = 1'b1;
        #1;
        chk("resume_valid", {31'h0, ir_valid}, 32'h1);
        @(negedge clk);
        #1;
        chk("resume_fetch", {22'h0, ir_valid, rom_ena, rom_addr}, {22'h0, 2'b01, 8'h01});
        @(negedge clk);
        #1;
        chk("resume_issue", {7'h0, ir_valid, ir_opcode, ir_operand, ir_pc}, {7'h0, 1'b1, 24'hF00001});
        @(negedge clk);
        #1;
        chk("halt_state", {28'h0, halted, fetch_err, ir_valid, rom_ena}, 32'h8);
        @(negedge clk);
        #1;
        chk("halt_sticky", {28'h0, halted, fetch_err, ir_valid, rom_ena}, 32'h8);
        rst_n = 1'b0;
        #1;
        chk("restart_reset", {22'h0, halted, rom_ena, rom_addr}, {22'h0, 2'b01, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("restart_issue", {7'h0, ir_valid, ir_opcode, ir_operand, ir_pc}, {7'h0, 1'b1, 24'h800000});

        // ---------------- reset in the middle of a 2-byte fetch ----------------
        tname = "mid_reset";
        clear_rom();
        rom[0] = 8'h11; rom[1] = 8'h41;
        apply_reset();
        ir_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("before_reset", {14'h0, rom_ena, rom_addr, ir_opcode}, {14'h0, 1'b1, 8'h01, 8'h11});
        rst_n = 1'b0;
        #1;
        chk("discarded", {7'h0, ir_valid, ir_opcode, ir_operand, ir_pc}, 32'h0);
        chk("pc_reset", {24'h0, rom_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check(12);
        if (got_q.size() > 0) chk("first_xfer", got_q[0], 32'h11_41_00_02);
        else chk("first_xfer_count", 32'(got_q.size()), 32'h1);

        // ---------------- random programs with random back pressure ----------------
        for (int p = 0; p < 24; p++) begin
            for (int a = 0; a < 256; a++) begin
                b = 8'($urandom_range(0, 255));
                if (b[7:4] == 4'hF && $urandom_range(0, 3) != 0) b[7:4] = 4'($urandom_range(0, 14));
                rom[a] = b;
            end
            if (p % 3 == 0) begin
                rom[0] = 8'hA0;
                rom[1] = 8'($urandom_range(248, 255));
            end
            thr = (p % 4 == 0) ? 100 : int'($urandom_range(30, 90));
            for (int k = 0; k < HMAX; k++) ready_pat[k] = (int'($urandom_range(0, 99)) < thr);
            tname = $sformatf("R%0d", p);
            apply_reset();
            run_check(200);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
